ibus_mem_responder: RTL and testbench
=====================================

Name: ibus_mem_responder

Overview:
Responder end of the instruction-fetch bus. It accepts fetch commands, reads a word from on-chip instruction SRAM and returns the instruction or an error after a fixed, pipelined latency. It sits between the core's fetch port and instruction memory. A side loader port fills the memory for boot and test.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words; power of two, ≥4.
READ_LATENCY, 2, cycles from command acceptance to response; integer ≥1.
AW, $clog2(DEPTH_WORDS), word-index width (derived, localparam).

Ports:
clk  input  1  clock, all state on rising edge.
rstf  input  1  asynchronous active-low reset.
iBus_cmd_valid  input  1  fetch request.
iBus_cmd_ready  output  1  responder can accept this cycle.
iBus_cmd_payload_pc  input  32  byte address of fetch.
iBus_rsp_ready  output  1  response valid strobe, one cycle; no backpressure.
iBus_rsp_err  output  1  response is an error; qualified by iBus_rsp_ready.
iBus_rsp_inst  output  32  fetched instruction; qualified by iBus_rsp_ready.
ibus_flush  input  1  discard all in-flight responses (core redirect).
load_valid  input  1  loader write strobe.
load_addr  input  AW  loader word index.
load_data  input  32  loader write data.

Behaviour:
- One clock. Reset is asynchronous and active-low on rstf.
- Reset (rstf=0, async):
  - All pipeline valid bits clear.
  - iBus_cmd_ready=0, iBus_rsp_ready=0, iBus_rsp_err=0, iBus_rsp_inst=32'h0.
  - Memory contents are not reset.
- Ready:
  - An internal rst_done flop sets on the first edge after rstf releases.
  - iBus_cmd_ready = rst_done & ~load_valid. It is combinational from load_valid and independent of iBus_cmd_valid.
- Accept:
  - A command is accepted on an edge where iBus_cmd_valid & iBus_cmd_ready.
  - Accepted commands are pipelined: up to one per cycle, with no outstanding limit other than READ_LATENCY.
- Latency:
  - A command accepted at edge N produces iBus_rsp_ready=1 during the cycle following edge N+READ_LATENCY-1.
  - With READ_LATENCY=1, the response is visible in the cycle right after acceptance.
  - Responses return strictly in order. Back-to-back accepts give back-to-back responses.
- Error classification, decided at acceptance:
  - err if pc[1:0]!=0 (misaligned), or pc[31:2] >= DEPTH_WORDS (out of range).
  - On err: iBus_rsp_err=1 and iBus_rsp_inst=32'h0. The memory read is still harmless.
  - Otherwise: iBus_rsp_err=0 and iBus_rsp_inst=mem[pc[AW+1:2]].
- Memory read timing:
  - Memory is read on the acceptance edge; later stages only delay the result.
  - A loader write to the same word on a later edge does not alter an in-flight response (old data).
- Loader:
  - When load_valid=1, mem[load_addr] <= load_data at the edge.
  - Commands are not accepted that cycle (ready=0), so no same-cycle read/write conflict exists.
  - In-flight responses continue to drain during loading.
- Flush:
  - ibus_flush=1 at edge E clears every in-flight valid bit, so no response appears for commands accepted before E.
  - A command accepted at the same edge E is kept and responds normally.
  - A flush with nothing in flight has no effect.
- Idle outputs:
  - When iBus_rsp_ready=0, iBus_rsp_err=0 and iBus_rsp_inst holds its last value. Consumers must ignore it.
- Reset mid-operation: all in-flight responses are dropped immediately and iBus_cmd_ready drops asynchronously.
- iBus_cmd_payload_pc is don't-care when iBus_cmd_valid=0. There is no X propagation into valid bits.

Decomposition:
- Package riscv_bus_pkg:
  - INST_NOP = 32'h0000_0013 (for benches and core use).
  - IBUS_ERR_INST = 32'h0.
  - ibus_rsp_t struct {logic err; logic [31:0] inst}.
- Sub-module ibus_rsp_pipe:
  - Parameterised READ_LATENCY-1 stage delay line of {valid, ibus_rsp_t}.
  - Has a flush input that clears the valid bits.
  - A pass-through when READ_LATENCY=1.
- Top holds the SRAM array, error classification, ready logic and loader.

Test Plan:
1. Reset with rstf=0 mid-cycle → all outputs 0 asynchronously. After release, iBus_cmd_ready=0 for one edge, then 1.
2. Loader writes mem[0..3]=32'h00000013,32'h00100093,32'h00200113,32'h00308193; fetch pc=0,4,8,12 back-to-back, READ_LATENCY=2 → four consecutive rsp_ready cycles starting 2 cycles after first accept, inst in order, err=0.
3. Fetch pc=32'h2 → err=1, inst=0. Fetch pc=DEPTH_WORDS*4 (32'h1000) → err=1. Fetch pc=32'hFFC (last word) → err=0, data returned.
4. Hold load_valid=1 while cmd_valid=1 → cmd_ready=0, no accept. A prior in-flight fetch of the same word returns the old data, and a fetch after the load returns the new data.
5. Accept pc=0 and pc=4, then assert ibus_flush together with accepting pc=8 → only the pc=8 response appears, 2 cycles later.
6. Accept 3 fetches, pull rstf low before responses arrive → no rsp_ready after reset release; the next fetch behaves normally.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared instruction-bus types and constants for the fetch path.
package riscv_bus_pkg;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [31:0] IBUS_ERR_INST = 32'h0000_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } ibus_rsp_t;

  // A fetch is an error if it is misaligned or its word index falls outside the array.
  function automatic logic ibus_pc_err(input logic [31:0] pc, input int unsigned depth_words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/ibus_mem_responder_if.sv
// Fetch bus plus loader port between the core/boot logic and the instruction memory.
interface ibus_mem_responder_if #(
  parameter int unsigned AW = 10
);
  logic          iBus_cmd_valid;
  logic          iBus_cmd_ready;
  logic [31:0]   iBus_cmd_payload_pc;
  logic          iBus_rsp_ready;
  logic          iBus_rsp_err;
  logic [31:0]   iBus_rsp_inst;
  logic          ibus_flush;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  modport slave (
    input  iBus_cmd_valid, iBus_cmd_payload_pc, ibus_flush, load_valid, load_addr, load_data,
    output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst
  );

  modport master (
    output iBus_cmd_valid, iBus_cmd_payload_pc, ibus_flush, load_valid, load_addr, load_data,
    input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst
  );
endinterface

// File: rtl/ibus_rsp_pipe.sv
// Delay line for fetch responses; flush drops everything already inside it.
module ibus_rsp_pipe
  import riscv_bus_pkg::*;
#(
  parameter int unsigned Stages = 1
) (
  input  logic      clk,
  input  logic      rstf,
  input  logic      flush,
  input  logic      src_valid,
  input  ibus_rsp_t src_rsp,
  output logic      dst_valid,
  output ibus_rsp_t dst_rsp
);

  if (Stages == 0) begin : g_bypass
    assign dst_valid = src_valid;
    assign dst_rsp   = src_rsp;

    logic unused_ok;
    assign unused_ok = ^{clk, rstf, flush};
  end else begin : g_stages
    logic      [Stages-1:0] valid_q;
    ibus_rsp_t [Stages-1:0] rsp_q;

    // Valid bits shift forward each cycle; a flush kills every entry already in flight.
    always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= src_valid & ~flush;
        for (int unsigned i = 1; i < Stages; i++) begin
          valid_q[i] <= valid_q[i-1] & ~flush;
        end
      end
    end

    // Payload only advances behind a valid entry so the idle output holds its last value.
    always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
        rsp_q <= '0;
      end else begin
        if (src_valid) begin
          rsp_q[0] <= src_rsp;
        end
        for (int unsigned i = 1; i < Stages; i++) begin
          if (valid_q[i-1]) begin
            rsp_q[i] <= rsp_q[i-1];
          end
        end
      end
    end

    assign dst_valid = valid_q[Stages-1];
    assign dst_rsp   = rsp_q[Stages-1];
  end

endmodule

// File: rtl/ibus_mem_responder.sv
// Instruction-fetch responder: SRAM read on acceptance, fixed-latency in-order responses.
module ibus_mem_responder
  import riscv_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstf,
  ibus_mem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic          rst_done_q;
  logic          accept;
  logic          cmd_err;
  logic [AW-1:0] rd_idx;
  logic          rd_valid_q;
  ibus_rsp_t     rd_rsp_q;
  logic          out_valid;
  ibus_rsp_t     out_rsp;

  // Loader writes own the cycle, so a read and a write never meet on the same edge.
  assign bus.iBus_cmd_ready = rst_done_q & ~bus.load_valid;
  assign accept             = bus.iBus_cmd_valid & bus.iBus_cmd_ready;
  assign cmd_err            = ibus_pc_err(bus.iBus_cmd_payload_pc, DEPTH_WORDS);
  assign rd_idx             = bus.iBus_cmd_payload_pc[AW+1:2];

  // Loader write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.load_valid) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // First stage: ready-after-reset flag and the SRAM read captured on the accept edge.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      rst_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_rsp_q   <= '0;
    end else begin
      rst_done_q <= 1'b1;
      rd_valid_q <= accept;
      if (accept) begin
        rd_rsp_q.err  <= cmd_err;
        rd_rsp_q.inst <= cmd_err ? IBUS_ERR_INST : mem[rd_idx];
      end
    end
  end

  ibus_rsp_pipe #(
    .Stages(READ_LATENCY - 1)
  ) u_rsp_pipe (
    .clk      (clk),
    .rstf     (rstf),
    .flush    (bus.ibus_flush),
    .src_valid(rd_valid_q),
    .src_rsp  (rd_rsp_q),
    .dst_valid(out_valid),
    .dst_rsp  (out_rsp)
  );

  assign bus.iBus_rsp_ready = out_valid;
  assign bus.iBus_rsp_err   = out_valid & out_rsp.err;
  assign bus.iBus_rsp_inst  = out_rsp.inst;

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Randomised scoreboard bench for the instruction-fetch responder.
module tb_ibus_mem_responder;
  import riscv_bus_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned AW    = 10;

  typedef struct {
    logic        err;
    logic [31:0] inst;
    int unsigned due;
    logic [31:0] pc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstf = 1'b0;
  always #5 clk = ~clk;

  ibus_mem_responder_if #(.AW(AW)) bus ();

  ibus_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rstf(rstf),
    .bus (bus)
  );

  exp_t        q[$];
  logic [31:0] model_mem [DEPTH];
  int unsigned cyc        = 0;
  bit          model_done = 1'b0;
  int          checks     = 0;
  int          errors     = 0;

  logic [31:0] m_pc;
  logic        m_err;
  exp_t        m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: evaluates each edge from the bus rules, pushes expected responses.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rstf) begin
      if (bus.ibus_flush) q.delete();
      if (bus.iBus_cmd_valid && model_done && !bus.load_valid) begin
        m_pc  = bus.iBus_cmd_payload_pc;
        m_err = (m_pc % 4 != 0) || ((m_pc / 4) >= DEPTH);
        q.push_back('{err: m_err, inst: m_err ? 32'h0 : model_mem[m_pc[AW+1:2]],
                      due: cyc + LAT - 1, pc: m_pc});
      end
      if (bus.load_valid) model_mem[bus.load_addr] = bus.load_data;
      model_done = 1'b1;
    end else begin
      model_done = 1'b0;
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the queue.
  initial forever begin
    @(negedge clk);
    if (rstf) begin
      check("cmd_ready", 32'(bus.iBus_cmd_ready), 32'(model_done && !bus.load_valid));
      if (bus.iBus_rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_ready=1 but nothing expected (cycle %0d)", cyc);
        end else begin
          m_e = q.pop_front();
          check("rsp_cycle", cyc, m_e.due);
          check("rsp_err", 32'(bus.iBus_rsp_err), 32'(m_e.err));
          check("rsp_inst", bus.iBus_rsp_inst, m_e.inst);
        end
      end else begin
        check("idle_err", 32'(bus.iBus_rsp_err), 32'd0);
        if (q.size() != 0 && q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rsp: pc %h due cycle %0d, no rsp_ready", q[0].pc, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iBus_cmd_valid      = 1'b0;
    bus.iBus_cmd_payload_pc = 32'h0;
    bus.ibus_flush          = 1'b0;
    bus.load_valid          = 1'b0;
    bus.load_addr           = '0;
    bus.load_data           = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.iBus_cmd_valid      = 1'b1;
    bus.iBus_cmd_payload_pc = pc;
    step();
    bus.iBus_cmd_valid      = 1'b0;
  endtask

  task automatic load(input int unsigned addr, input logic [31:0] data);
    bus.load_valid = 1'b1;
    bus.load_addr  = AW'(addr);
    bus.load_data  = data;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 2) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.iBus_cmd_ready), 32'd0);
    check({tag, "_rsp_ready"}, 32'(bus.iBus_rsp_ready), 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.iBus_rsp_err), 32'd0);
    check({tag, "_rsp_inst"}, bus.iBus_rsp_inst, 32'h0);
  endtask

  int unsigned r;

  initial begin
    clear_inputs();
    // Power-on reset, released mid-cycle; ready stays low until the next edge.
    #3;
    check_reset_outputs("por");
    #9;
    rstf = 1'b1;
    #1;
    check("post_release_ready", 32'(bus.iBus_cmd_ready), 32'd0);
    step();
    check("first_edge_ready", 32'(bus.iBus_cmd_ready), 32'd1);

    // Fill every word so any in-range fetch has defined data.
    for (int unsigned i = 0; i < DEPTH; i++) load(i, $urandom);

    // Boot program, fetched back to back.
    load(0, INST_NOP);
    load(1, 32'h0010_0093);
    load(2, 32'h0020_0113);
    load(3, 32'h0030_8193);
    for (int unsigned i = 0; i < 4; i++) fetch(32'(i * 4));
    drain();

    // Error classification boundaries.
    fetch(32'h0000_0002);
    fetch(32'h0000_1000);
    fetch(32'h0000_0FFC);
    fetch(32'hFFFF_FFFC);
    fetch(32'h0000_0FFF);
    drain();

    // In-flight read keeps old data; a load blocks acceptance; later fetch sees new data.
    fetch(32'd20);
    bus.iBus_cmd_valid      = 1'b1;
    bus.iBus_cmd_payload_pc = 32'd20;
    load(5, 32'hDEAD_BEEF);
    bus.iBus_cmd_valid      = 1'b0;
    fetch(32'd20);
    drain();

    // Flush together with a new accept: only the new command survives.
    fetch(32'd0);
    fetch(32'd4);
    bus.ibus_flush = 1'b1;
    fetch(32'd8);
    bus.ibus_flush = 1'b0;
    drain();

    // Flush with nothing in flight.
    bus.ibus_flush = 1'b1;
    step();
    bus.ibus_flush = 1'b0;
    fetch(32'd12);
    drain();

    // Asynchronous reset with fetches in flight.
    fetch(32'd0);
    fetch(32'd4);
    bus.iBus_cmd_valid      = 1'b1;
    bus.iBus_cmd_payload_pc = 32'd8;
    @(posedge clk);
    #2;
    rstf       = 1'b0;
    q.delete();
    model_done = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.iBus_cmd_valid = 1'b0;
    step();
    #3;
    rstf = 1'b1;
    step();
    step();
    fetch(32'd4);
    drain();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      bus.iBus_cmd_payload_pc = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 1) bus.iBus_cmd_payload_pc = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      else             bus.iBus_cmd_payload_pc = {20'h0, 10'($urandom), 2'b00};
      bus.iBus_cmd_valid = ($urandom_range(0, 9) < 7);
      bus.load_valid     = ($urandom_range(0, 99) < 15);
      bus.load_addr      = AW'($urandom_range(0, DEPTH - 1));
      bus.load_data      = $urandom;
      bus.ibus_flush     = ($urandom_range(0, 99) < 5);
      step();
    end
    clear_inputs();
    drain();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: %0d responses outstanding, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
